serial_subtractor: RTL and testbench

Bit-serial two's-complement subtractor, the inverse operation to the team's combinational full adder. It computes DIFF = A - B one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. Operands arrive over a valid/ready handshake and results leave over one. It serves as the area-minimal subtract unit for the adder/ALU datapath series.

---
 rtl/serial_subtractor.sv | 116 +++++++++++
 tb/tb_serial_subtractor.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first,
// through a single full-subtractor cell and a registered borrow.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, and the two never overlap.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;

    logic             ai;
    logic             bi;
    logic             d;
    logic             br_next;
    logic [WIDTH-1:0] res_next;

    // Full-subtractor cell
    assign ai       = a_sr[0];
    assign bi       = b_sr[0];
    assign d        = ai ^ bi ^ br;
    assign br_next  = (~ai & bi) | (~(ai ^ bi) & br);
    assign res_next = {d, res_sr};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            br        <= 1'b0;
            cnt       <= '0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        a_msb    <= a[WIDTH-1];
                        b_msb    <= b[WIDTH-1];
                        br       <= 1'b0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next[WIDTH-1:1];
                    br     <= br_next;
                    if (cnt == LAST) begin
                        // Result fields update only here so they hold between operations.
                        diff      <= res_next;
                        bout      <= br_next;
                        zero      <= (res_next == '0);
                        overflow  <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): hand-computed vectors, latency,
// backpressure, mid-operation reset, and a short randomized run against a reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         overflow;
    logic         zero;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected results packed as {bout, overflow, zero, diff}
    logic [W+2:0] exp_q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .overflow  (overflow),
        .zero      (zero)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W+2:0] ref_model(input logic [W-1:0] va, input logic [W-1:0] vb);
        logic [W:0]   wide;
        logic [W-1:0] dv;
        logic         ov;
        wide = {1'b0, va} - {1'b0, vb};
        dv   = wide[W-1:0];
        ov   = (va[W-1] != vb[W-1]) && (dv[W-1] != va[W-1]);
        return {wide[W], ov, (dv == '0), dv};
    endfunction

    // Driver tasks: all called at a negative edge and return at a negative edge.
    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", in_ready, 1'b1);
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
    endtask

    // Waits for the result (called right after send), optionally holds off out_ready
    // for `stall` cycles while poking in_valid, then completes the output handshake.
    task automatic receive(input int stall, input bit poke);
        int           edges;
        logic [W+2:0] e;
        logic [W-1:0] held;
        edges = 0;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        check("latency", edges, W);
        e = exp_q.pop_front();
        check("diff", diff, e[W-1:0]);
        check("bout", bout, e[W+2]);
        check("overflow", overflow, e[W+1]);
        check("zero", zero, e[W]);
        held = diff;
        for (int s = 0; s < stall; s++) begin
            if (poke && s == 1) begin
                in_valid = 1'b1;
                a        = 8'h01;
                b        = 8'h01;
            end
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            if (poke) begin
                check("hold_out_valid", out_valid, 1'b1);
                check("hold_in_ready", in_ready, 1'b0);
                check("hold_diff", diff, held);
                check("hold_flags", {bout, overflow, zero}, e[W+2:W]);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 1'b0);
        check("in_ready_return", in_ready, 1'b1);
    endtask

    task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W+2:0] exp_w, input int stall);
        exp_q.push_back(exp_w);
        send(va, vb);
        receive(stall, 1'b0);
    endtask

    // Hand-computed vectors: a, b, {bout, overflow, zero, diff}
    logic [W-1:0] va_t[10] = '{8'h35, 8'h12, 8'h5A, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'h80, 8'h7F, 8'h01};
    logic [W-1:0] vb_t[10] = '{8'h12, 8'h35, 8'h5A, 8'h01, 8'hFF, 8'h80, 8'h01, 8'h80, 8'h80, 8'hFF};
    logic [W+2:0] ve_t[10] = '{
        {3'b000, 8'h23}, {3'b100, 8'hDD}, {3'b001, 8'h00}, {3'b010, 8'h7F}, {3'b110, 8'h80},
        {3'b110, 8'h80}, {3'b000, 8'hFE}, {3'b001, 8'h00}, {3'b110, 8'hFF}, {3'b100, 8'h02}
    };

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_fields", {diff, bout, overflow, zero}, '0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_op(va_t[i], vb_t[i], ve_t[i], 0);
        end

        // Backpressure with an ignored in_valid pulse while the result waits
        exp_q.push_back({3'b000, 8'h23});
        send(8'h35, 8'h12);
        receive(5, 1'b1);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("no_phantom_op", {in_ready, out_valid}, 2'b10);
        end

        // Reset while bit 3 is being processed
        send(8'h33, 8'h11);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_fields", {diff, bout, overflow, zero}, '0);
        do_op(8'h01, 8'h02, {3'b100, 8'hFF}, 0);

        // Randomized operands and stalls against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            do_op(ra, rb, ref_model(ra, rb), int'($urandom_range(0, 3)));
        end
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
